// File: rtl/riscv_pkg.sv
`default_nettype none
// =============================================================================
// riscv_pkg : RV32 opcodes, instruction-format enum and ID/EX payload type
// Rev 1.0
// =============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            is_load;
    logic            we;
    logic            illegal;
  } idex_t;

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// =============================================================================
// imm_gen : sign-extended immediate for the I/S/B/U/J formats, zero for R
// Rev 1.0
// =============================================================================
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  input  fmt_e        fmt_i,
  output logic [31:0] imm_o
);

  // Opcode bits never contribute to an immediate.
  logic w_unused;
  assign w_unused = ^instr_i[6:0];

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      FMT_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      FMT_U:   imm_o = {instr_i[31:12], 12'b0};
      FMT_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// =============================================================================
// decode_stage : RV32 decode with ID/EX register, writeback bypass, load-use stall
// Rev 1.0
// =============================================================================
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_valid_i,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            id_ready_o,
  input  logic            ex_ready_i,
  input  logic            flush_i,
  output logic [4:0]      rf_rn1_o,
  output logic [4:0]      rf_rn2_o,
  input  logic [XLEN-1:0] rf_val1_i,
  input  logic [XLEN-1:0] rf_val2_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_wn_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rd_o,
  output logic [6:0]      ex_opcode_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_funct7b5_o,
  output logic            ex_is_load_o,
  output logic            ex_we_o,
  output logic            ex_illegal_o
);
  import riscv_pkg::*;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [2:0]      w_funct3;
  fmt_e            w_fmt;
  logic            w_legal, w_use_rs1, w_use_rs2, w_no_wb;
  logic [XLEN-1:0] w_op1, w_op2, w_imm;
  logic            w_load_use;
  idex_t           w_idex;
  idex_t           idex_d, idex_q;
  logic            valid_d, valid_q;

  assign w_opcode = if_instr_i[6:0];
  assign w_rd     = if_instr_i[11:7];
  assign w_funct3 = if_instr_i[14:12];
  assign w_rs1    = if_instr_i[19:15];
  assign w_rs2    = if_instr_i[24:20];
  assign rf_rn1_o = w_rs1;
  assign rf_rn2_o = w_rs2;

  always_comb begin
    w_fmt     = FMT_R;
    w_legal   = 1'b1;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_no_wb   = 1'b0;
    case (w_opcode)
      c_OPC_LUI, c_OPC_AUIPC: w_fmt = FMT_U;
      c_OPC_JAL:              w_fmt = FMT_J;
      c_OPC_JALR, c_OPC_LOAD, c_OPC_OPIMM: begin
        w_fmt     = FMT_I;
        w_use_rs1 = 1'b1;
      end
      c_OPC_BRANCH: begin
        w_fmt     = FMT_B;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_no_wb   = 1'b1;
      end
      c_OPC_STORE: begin
        w_fmt     = FMT_S;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_no_wb   = 1'b1;
      end
      c_OPC_OP: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      c_OPC_SYSTEM: begin
        // Only the register forms of CSRRW/CSRRS/CSRRC read rs1.
        w_fmt     = FMT_I;
        w_use_rs1 = !w_funct3[2] && (w_funct3[1:0] != 2'b00);
        w_no_wb   = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  imm_gen u_imm_gen (
    .instr_i (if_instr_i),
    .fmt_i   (w_fmt),
    .imm_o   (w_imm)
  );

  // A same-cycle writeback is newer than the register-file read.
  assign w_op1 = (w_rs1 == 5'd0) ? '0 :
                 (wb_we_i && (wb_wn_i == w_rs1)) ? wb_data_i : rf_val1_i;
  assign w_op2 = (w_rs2 == 5'd0) ? '0 :
                 (wb_we_i && (wb_wn_i == w_rs2)) ? wb_data_i : rf_val2_i;

  assign w_load_use = valid_q && idex_q.is_load && (idex_q.rd != 5'd0) &&
                      ((w_use_rs1 && (w_rs1 == idex_q.rd)) ||
                       (w_use_rs2 && (w_rs2 == idex_q.rd)));

  assign id_ready_o = flush_i || ((!valid_q || ex_ready_i) && !w_load_use);

  always_comb begin
    w_idex          = '0;
    w_idex.pc       = if_pc_i;
    w_idex.op1      = w_op1;
    w_idex.op2      = w_op2;
    w_idex.imm      = w_imm;
    w_idex.rd       = w_rd;
    w_idex.opcode   = w_opcode;
    w_idex.funct3   = w_funct3;
    w_idex.funct7b5 = if_instr_i[30];
    w_idex.is_load  = (w_opcode == c_OPC_LOAD);
    w_idex.we       = w_legal && !w_no_wb && (w_rd != 5'd0);
    w_idex.illegal  = !w_legal;
  end

  always_comb begin
    idex_d  = idex_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (if_valid_i && id_ready_o) begin
      valid_d = 1'b1;
      idex_d  = w_idex;
    end else if (ex_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_pc_o       = idex_q.pc;
  assign ex_op1_o      = idex_q.op1;
  assign ex_op2_o      = idex_q.op2;
  assign ex_imm_o      = idex_q.imm;
  assign ex_rd_o       = idex_q.rd;
  assign ex_opcode_o   = idex_q.opcode;
  assign ex_funct3_o   = idex_q.funct3;
  assign ex_funct7b5_o = idex_q.funct7b5;
  assign ex_is_load_o  = idex_q.is_load;
  assign ex_we_o       = idex_q.we;
  assign ex_illegal_o  = idex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`timescale 1ns/100ps
`default_nettype none
// =============================================================================
// tb_decode_stage : scoreboard bench with a reference decode model
// Rev 1.0
// =============================================================================
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        id_ready;
  logic        ex_ready = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  rf_rn1, rf_rn2;
  logic [31:0] rf_val1, rf_val2;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_wn = '0;
  logic [31:0] wb_data = '0;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_is_load, ex_we, ex_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .if_instr_i(if_instr),
    .if_pc_i(if_pc), .id_ready_o(id_ready), .ex_ready_i(ex_ready), .flush_i(flush),
    .rf_rn1_o(rf_rn1), .rf_rn2_o(rf_rn2), .rf_val1_i(rf_val1), .rf_val2_i(rf_val2),
    .wb_we_i(wb_we), .wb_wn_i(wb_wn), .wb_data_i(wb_data), .ex_valid_o(ex_valid),
    .ex_pc_o(ex_pc), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .ex_imm_o(ex_imm),
    .ex_rd_o(ex_rd), .ex_opcode_o(ex_opcode), .ex_funct3_o(ex_funct3),
    .ex_funct7b5_o(ex_funct7b5), .ex_is_load_o(ex_is_load), .ex_we_o(ex_we),
    .ex_illegal_o(ex_illegal)
  );

  typedef struct {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5, is_load, we, illegal;
  } exp_t;

  localparam logic [6:0] OPCS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                       7'h23, 7'h13, 7'h33, 7'h73, 7'h7F};

  exp_t        sb_q[$];
  logic [31:0] regs [32];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_ready = 1'b1;
  logic        held_load = 1'b0;
  logic [4:0]  held_rd = '0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  // The external register file has no internal bypass: writes land after the edge.
  assign rf_val1 = regs[if_instr[19:15]];
  assign rf_val2 = regs[if_instr[24:20]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] m = 32'd1 << (bits - 1);
    return (v ^ m) - m;
  endfunction

  function automatic logic uses1(input logic [31:0] ins);
    case (ins[6:0])
      7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33: return 1'b1;
      7'h73: return (ins[14:12] >= 3'd1) && (ins[14:12] <= 3'd3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses2(input logic [31:0] ins);
    return (ins[6:0] == 7'h63) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h33);
  endfunction

  function automatic logic hazard(input logic [31:0] ins);
    return exp_valid && held_load && (held_rd != 0) &&
           ((uses1(ins) && ins[19:15] == held_rd) || (uses2(ins) && ins[24:20] == held_rd));
  endfunction

  function automatic logic [31:0] src(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_we && wb_wn == r) return wb_data;
    return regs[r];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic legal = 1'b1;
    e.pc = pc; e.rd = ins[11:7]; e.opc = ins[6:0]; e.f3 = ins[14:12]; e.f7b5 = ins[30];
    e.op1 = src(ins[19:15]);
    e.op2 = src(ins[24:20]);
    e.is_load = (ins[6:0] == 7'h03);
    e.imm = 32'd0;
    case (ins[6:0])
      7'h37, 7'h17: e.imm = ins & 32'hFFFF_F000;
      7'h6F: e.imm = sx({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      7'h67, 7'h03, 7'h13, 7'h73: e.imm = sx(ins >> 20, 12);
      7'h63: e.imm = sx({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      7'h23: e.imm = sx({ins[31:25], ins[11:7]}, 12);
      7'h33: e.imm = 32'd0;
      default: legal = 1'b0;
    endcase
    e.illegal = !legal;
    e.we = legal && (e.rd != 0) && !(ins[6:0] inside {7'h23, 7'h63, 7'h73});
    return e;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, ex_valid, 0);
    chk({tag, "_pc"}, ex_pc, 0);
    chk({tag, "_op1"}, ex_op1, 0);
    chk({tag, "_op2"}, ex_op2, 0);
    chk({tag, "_imm"}, ex_imm, 0);
    chk({tag, "_fields"}, {ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_we, ex_illegal}, 0);
    chk({tag, "_id_ready"}, id_ready, 1);
  endtask

  // One clock of stimulus plus the model update for that clock.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                       input logic we, input logic [4:0] wn, input logic [31:0] wd,
                       input logic rst_pulse);
    @(negedge clk);
    if_valid = v; if_instr = ins; if_pc = pc_ctr; ex_ready = rdy; flush = fl;
    wb_we = we; wb_wn = wn; wb_data = wd;
    exp_ready = fl || ((!exp_valid || rdy) && !hazard(ins));
    if (rst_pulse) begin
      #3 rst_n = 1'b0;
      #0.5 chk_reset_state("async_rst");
      sb_q.delete();
      exp_valid = 1'b0;
      #0.5 rst_n = 1'b1;
    end
    @(posedge clk);
    #1;
    if (fl) begin
      if (exp_valid && !rdy && sb_q.size() > 0) void'(sb_q.pop_back());
      exp_valid = 1'b0;
    end else if (v && (!exp_valid || rdy) && !hazard(ins)) begin
      sb_q.push_back(model(ins, pc_ctr));
      exp_valid = 1'b1;
      held_load = (ins[6:0] == 7'h03);
      held_rd = ins[11:7];
      pc_ctr += 4;
    end else if (rdy) begin
      exp_valid = 1'b0;
    end
    if (we && wn != 0) regs[wn] = wd;
  endtask

  // Monitor: compares the presented ID/EX contents against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("id_ready", id_ready, exp_ready);
        chk("ex_valid", ex_valid, exp_valid);
        chk("rf_rn1", rf_rn1, if_instr[19:15]);
        chk("rf_rn2", rf_rn2, if_instr[24:20]);
        if (exp_valid) begin
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty: got valid instruction expected none queued");
          end else begin
            chk("ex_pc", ex_pc, sb_q[0].pc);
            chk("ex_op1", ex_op1, sb_q[0].op1);
            chk("ex_op2", ex_op2, sb_q[0].op2);
            chk("ex_imm", ex_imm, sb_q[0].imm);
            chk("ex_rd", ex_rd, sb_q[0].rd);
            chk("ex_opcode", ex_opcode, sb_q[0].opc);
            chk("ex_funct3", ex_funct3, sb_q[0].f3);
            chk("ex_funct7b5", ex_funct7b5, sb_q[0].f7b5);
            chk("ex_is_load", ex_is_load, sb_q[0].is_load);
            chk("ex_we", ex_we, sb_q[0].we);
            chk("ex_illegal", ex_illegal, sb_q[0].illegal);
            if (ex_ready) void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] addi_m3, lw_x3, add_x3, add_byp, addi_a, addi_b, ill;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 * i + 32'h11;
    regs[0] = 0; regs[1] = 32'd10; regs[7] = 32'h1111_1111;
    addi_m3 = {12'hFFD, 5'd1, 3'b000, 5'd5, 7'h13};
    lw_x3   = {12'd0, 5'd2, 3'b010, 5'd3, 7'h03};
    add_x3  = {7'd0, 5'd3, 5'd3, 3'b000, 5'd4, 7'h33};
    add_byp = {7'd0, 5'd0, 5'd7, 3'b000, 5'd8, 7'h33};
    addi_a  = {12'h123, 5'd2, 3'b000, 5'd6, 7'h13};
    addi_b  = {12'h800, 5'd6, 3'b000, 5'd9, 7'h13};
    ill     = {25'h1ABCDE, 7'h7F};

    repeat (2) @(negedge clk);
    #1 chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // ADDI x5,x1,-3
    cycle(1, addi_m3, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    // Load-use: LW x3 then ADD x4,x3,x3 (one bubble)
    cycle(1, lw_x3, 1, 0, 0, 0, 0, 0);
    cycle(1, add_x3, 1, 0, 0, 0, 0, 0);
    cycle(1, add_x3, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    // Writeback bypass with stale rf_val1
    cycle(1, add_byp, 1, 0, 1, 5'd7, 32'hCAFE_0000, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    // Backpressure for three cycles
    cycle(1, addi_a, 1, 0, 0, 0, 0, 0);
    repeat (3) cycle(1, addi_b, 0, 0, 0, 0, 0, 0);
    cycle(1, addi_b, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    // Flush while stalled on load-use
    cycle(1, lw_x3, 1, 0, 0, 0, 0, 0);
    cycle(1, add_x3, 0, 0, 0, 0, 0, 0);
    cycle(1, add_x3, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    // Illegal opcode, then async reset while it is held
    cycle(1, ill, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r, ins;
      r = $urandom;
      ins = {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[14:12],
             5'($urandom_range(0, 7)), OPCS[$urandom_range(0, 10)]};
      cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 299) == 0);
    end
    repeat (3) cycle(0, 0, 1, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_instr  in  32  instruction word.
REQ-006 if_pc  in  32  PC of if_instr.
REQ-007 id_ready  out  1  decode accepts if_instr this cycle.
REQ-008 ex_ready  in  1  execute accepts ex_* this cycle.
REQ-009 flush  in  1  discard held and incoming instruction (branch redirect).
REQ-010 rf_rn1, rf_rn2  out  5  register-file read numbers, driven combinationally from if_instr[19:15] and if_instr[24:20].
REQ-011 rf_val1, rf_val2  in  32  register-file read data.
REQ-012 wb_we, wb_wn, wb_data  in  1/5/32  writeback port, also wired to the register file.
REQ-013 ex_valid  out  1  ID/EX register holds a valid instruction.
REQ-014 ex_pc, ex_op1, ex_op2, ex_imm  out  32 each  registered PC, rs1 value, rs2 value, immediate.
REQ-015 ex_rd  out  5, ex_opcode  out  7, ex_funct3  out  3, ex_funct7b5  out  1  registered fields.
REQ-016 ex_is_load, ex_we, ex_illegal  out  1 each  load flag, rd write enable, illegal-opcode flag.

Function
REQ-017 Transfer: an instruction moves into ID/EX when if_valid && id_ready; ex_* update on the same edge; latency one cycle.
REQ-018 id_ready = (!ex_valid || ex_ready) && !load_use, where load_use = ex_valid && ex_is_load && ex_rd!=0 && ex_rd matches a source register actually used by if_instr.
REQ-019 Load-use: while load_use and ex_ready, the edge sets ex_valid=0 (one bubble); the next cycle sees no hazard and accepts the instruction.
REQ-020 Hold: with ex_valid=1 and ex_ready=0, every ex_* output keeps its value.
REQ-021 With ex_ready=1 and no accepted instruction, ex_valid goes to 0 on the next edge.
REQ-022 Operand select per source: reg 0 -> 0; else if wb_we && wb_wn==rs -> wb_data; else rf_val.
REQ-023 Immediates: I, S, B, U and J formats, sign-extended from instr[31]; B and J have bit0=0; R-type gives 0.
REQ-024 Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM.
REQ-025 Any other opcode sets ex_illegal=1 and ex_we=0, and keeps ex_valid=1 so execute can trap.
REQ-026 ex_we = 0 for STORE, BRANCH, SYSTEM, and whenever rd==0; otherwise 1.
REQ-027 Flush has priority over all else: the next edge sets ex_valid=0; id_ready=1 during flush and any if_valid instruction is dropped.
REQ-028 Simultaneous flush and load_use: flush wins and the stall is released.

Reset
REQ-029 While rst_n=0: ex_valid=0 and all other ex_* registers = 0; id_ready reflects the empty state (1).
REQ-030 Reset asserted mid-transfer discards the held instruction; no partial update is visible.

Structure
REQ-031 A shared riscv_pkg holds the opcode constants, the instruction-format enum (R, I, S, B, U, J) and XLEN; execute reuses it.
REQ-032 Sub-module imm_gen (combinational: instr in, format in, imm out) is instantiated once.

Verification
REQ-033 Scenario 1, ADDI: ADDI x5,x1,-3 with x1=10, ex_ready=1.
- Next cycle: ex_op1=10, ex_imm=0xFFFFFFFD, ex_rd=5, ex_we=1.
REQ-034 Scenario 2, load-use: LW x3,0(x2) followed by ADD x4,x3,x3.
- One bubble (ex_valid=0) is inserted.
- id_ready=0 for exactly one cycle.
- ADD then issues.
REQ-035 Scenario 3, bypass: wb_we=1, wb_wn=7, wb_data=0xCAFE0000 while decoding ADD x8,x7,x0 with rf_val1 stale.
- Result: ex_op1=0xCAFE0000, ex_op2=0.
REQ-036 Scenario 4, backpressure: ex_ready=0 for 3 cycles.
- ex_* stable throughout; id_ready=0; no instruction lost.
- Issue resumes in order when ex_ready returns to 1.
REQ-037 Scenario 5, flush during load_use stall: flush=1.
- Next cycle ex_valid=0.
- The stalled instruction never appears on ex_*.
REQ-038 Scenario 6, illegal opcode and reset: opcode 0x7F.
- Result: ex_illegal=1, ex_we=0.
- Asynchronous rst_n pulse mid-cycle clears ex_valid immediately.
